// File: rtl/scene_streamer.sv
// Streams projected triangle faces from a local face RAM into a write FIFO, one frame at a time.
// Optional feature: define BACKFACE_CULL_EN to drop faces that are not front-facing on screen.
module scene_streamer #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned COORD_W = 10,
   parameter int unsigned SCR_W   = 10,
   parameter int unsigned COLOR_W = 6,
   parameter int unsigned SHIFT   = 5,
   parameter int unsigned STEP    = 4,
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1),
   localparam int unsigned ADDR_W = $clog2(DEPTH),
   localparam int unsigned FACE_W = 9 * COORD_W + COLOR_W,
   localparam int unsigned PKT_W  = 6 * SCR_W + COLOR_W
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
   input  logic [CNT_W-1:0]        num_faces,
   input  logic                    ld_en,
   input  logic [ADDR_W-1:0]       ld_addr,
   input  logic [FACE_W-1:0]       ld_data,
   input  logic [4:0]              btns,
   input  logic                    fifo_full,
   input  logic                    fifo_empty,
   output logic                    wen,
   output logic [PKT_W-1:0]        write_data,
   output logic                    frame_done,
   output logic                    busy,
   output logic signed [SCR_W-1:0] cam_x,
   output logic signed [SCR_W-1:0] cam_y
);
   localparam int unsigned PW = COORD_W + SHIFT + 2;

   typedef enum logic [1:0] {StIdle, StFetch, StEmit, StDrain} state_e;

   state_e                  state_q, state_d;
   logic [FACE_W-1:0]       mem [DEPTH];
   logic [FACE_W-1:0]       face_q;
   logic [ADDR_W-1:0]       fetch_addr;
   logic [CNT_W-1:0]        n_q, n_d, idx_q, idx_d, n_lim;
   logic signed [SCR_W-1:0] cam_x_q, cam_x_d, cam_y_q, cam_y_d;
   logic [PKT_W-1:0]        pkt, wd_q;
   logic [SCR_W-1:0]        sx [3];
   logic [SCR_W-1:0]        sy [3];
   logic                    last, cull, wen_c, done_c, emit;

   function automatic logic [SCR_W-1:0] project(input logic [COORD_W-1:0] v,
                                                input logic [COORD_W-1:0] vz,
                                                input logic [SCR_W-1:0]   cam);
      logic signed [PW-1:0] sv, sz, sc, s;
      sv = {{(PW - COORD_W){v[COORD_W-1]}}, v};
      sz = {{(PW - COORD_W){vz[COORD_W-1]}}, vz};
      sc = {{(PW - SCR_W){cam[SCR_W-1]}}, cam};
      s  = sc + (sv <<< SHIFT) - (sz <<< (SHIFT - 1));
      return s[SCR_W-1:0];
   endfunction

   for (genvar k = 0; k < 3; k++) begin : g_vert
      localparam int unsigned Base = FACE_W - 1 - 3 * k * COORD_W;
      assign sx[k] = project(face_q[Base -: COORD_W], face_q[Base - 2 * COORD_W -: COORD_W],
                             cam_x_q);
      assign sy[k] = project(face_q[Base - COORD_W -: COORD_W],
                             face_q[Base - 2 * COORD_W -: COORD_W], cam_y_q);
   end

   assign pkt = {sx[0], sy[0], sx[1], sy[1], sx[2], sy[2], face_q[COLOR_W-1:0]};

`ifdef BACKFACE_CULL_EN
   localparam int unsigned AW = 2 * SCR_W + 3;
   logic signed [AW-1:0] ex [3];
   logic signed [AW-1:0] ey [3];
   logic signed [AW-1:0] area;
   for (genvar k = 0; k < 3; k++) begin : g_ext
      assign ex[k] = {{(AW - SCR_W){sx[k][SCR_W-1]}}, sx[k]};
      assign ey[k] = {{(AW - SCR_W){sy[k][SCR_W-1]}}, sy[k]};
   end
   assign area = (ex[1] - ex[0]) * (ey[2] - ey[0]) - (ex[2] - ex[0]) * (ey[1] - ey[0]);
   // Non-negative area is a back-facing or degenerate triangle.
   assign cull = ~area[AW-1];
`else
   assign cull = 1'b0;
`endif

   assign n_lim      = (num_faces > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_faces;
   assign last       = (idx_q == n_q - CNT_W'(1));
   assign fetch_addr = idx_q[ADDR_W-1:0];

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      idx_d   = idx_q;
      cam_x_d = cam_x_q;
      cam_y_d = cam_y_q;
      wen_c   = 1'b0;
      done_c  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (run) begin
               n_d     = n_lim;
               idx_d   = '0;
               state_d = (n_lim != '0) ? StFetch : StDrain;
            end
         end
         StFetch: state_d = StEmit;
         StEmit: begin
            if (cull || !fifo_full) begin
               wen_c   = ~cull;
               idx_d   = idx_q + CNT_W'(1);
               state_d = last ? StDrain : StFetch;
            end
         end
         StDrain: begin
            if (fifo_empty) begin
               done_c = 1'b1;
               if (btns[0]) begin
                  cam_x_d = '0;
                  cam_y_d = '0;
               end else begin
                  if (btns[1] && !btns[2]) cam_x_d = cam_x_q + SCR_W'(STEP);
                  if (btns[2] && !btns[1]) cam_x_d = cam_x_q - SCR_W'(STEP);
                  if (btns[3] && !btns[4]) cam_y_d = cam_y_q + SCR_W'(STEP);
                  if (btns[4] && !btns[3]) cam_y_d = cam_y_q - SCR_W'(STEP);
               end
               if (!run) begin
                  state_d = StIdle;
               end else begin
                  n_d     = n_lim;
                  idx_d   = '0;
                  state_d = (n_lim != '0) ? StFetch : StDrain;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Reset also masks the strobes in its own cycle so an aborted frame emits nothing.
   assign emit       = wen_c & ~reset;
   assign wen        = emit;
   assign frame_done = done_c & ~reset;
   assign write_data = emit ? pkt : wd_q;
   assign busy       = (state_q != StIdle);
   assign cam_x      = cam_x_q;
   assign cam_y      = cam_y_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         n_q     <= '0;
         idx_q   <= '0;
         cam_x_q <= '0;
         cam_y_q <= '0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         idx_q   <= idx_d;
         cam_x_q <= cam_x_d;
         cam_y_q <= cam_y_d;
         if (emit) wd_q <= pkt;
      end
   end

   // Same-cycle load to the fetched address is forwarded into the face register.
   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
      if (state_q == StFetch) begin
         face_q <= (ld_en && (ld_addr == fetch_addr)) ? ld_data : mem[fetch_addr];
      end
   end

endmodule
